// File: rtl/mux_sel_sequencer.sv
// Steps a mux select through a programmed table of (select, hold) entries and
// captures the mux output at the end of every step into a bit vector.
module mux_sel_sequencer #(
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [HOLD_W-1:0]          cfg_hold,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mux_out,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy,
  output logic                       sample_valid,
  output logic                       done,
  output logic [DEPTH-1:0]           capture
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_r;
  logic [SEL_W-1:0]  tbl_sel_r  [DEPTH];
  logic [HOLD_W-1:0] tbl_hold_r [DEPTH];
  logic [AW-1:0]     step_r;
  logic [LW-1:0]     lenq_r;
  logic [HOLD_W-1:0] cnt_r;
  logic [SEL_W-1:0]  sel_r;
  logic              busy_r;
  logic              sample_valid_r;
  logic              done_r;
  logic [DEPTH-1:0]  capture_r;

  logic              start_ok_s;
  logic [LW-1:0]     len_clip_s;
  logic [AW-1:0]     step_nxt_s;
  logic              last_step_s;

  // Start qualification, length clipping and end-of-sequence detection.
  always_comb begin
    start_ok_s  = start && !abort && (len != {LW{1'b0}});
    if (len > LW'(DEPTH)) begin
      len_clip_s = LW'(DEPTH);
    end else begin
      len_clip_s = len;
    end
    step_nxt_s  = step_r + AW'(1);
    last_step_s = (({1'b0, step_r} + LW'(1)) >= lenq_r);
  end

  // Sequencer state, table storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      step_r         <= {AW{1'b0}};
      lenq_r         <= {LW{1'b0}};
      cnt_r          <= {HOLD_W{1'b0}};
      sel_r          <= {SEL_W{1'b0}};
      busy_r         <= 1'b0;
      sample_valid_r <= 1'b0;
      done_r         <= 1'b0;
      capture_r      <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tbl_sel_r[i]  <= {SEL_W{1'b0}};
        tbl_hold_r[i] <= {HOLD_W{1'b0}};
      end
    end else begin
      sample_valid_r <= 1'b0;
      done_r         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_we) begin
            tbl_sel_r[cfg_addr]  <= cfg_sel;
            tbl_hold_r[cfg_addr] <= cfg_hold;
          end
          // Table reads here see the pre-write contents when cfg_we and start coincide.
          if (start_ok_s) begin
            capture_r <= {DEPTH{1'b0}};
            step_r    <= {AW{1'b0}};
            lenq_r    <= len_clip_s;
            sel_r     <= tbl_sel_r[0];
            cnt_r     <= tbl_hold_r[0];
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            sel_r   <= {SEL_W{1'b0}};
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r != {HOLD_W{1'b0}}) begin
            cnt_r <= cnt_r - HOLD_W'(1);
          end else begin
            capture_r[step_r] <= mux_out;
            sample_valid_r    <= 1'b1;
            if (!last_step_s) begin
              step_r <= step_nxt_s;
              sel_r  <= tbl_sel_r[step_nxt_s];
              cnt_r  <= tbl_hold_r[step_nxt_s];
            end else begin
              sel_r   <= {SEL_W{1'b0}};
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          sel_r   <= {SEL_W{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sel          = sel_r;
  assign busy         = busy_r;
  assign sample_valid = sample_valid_r;
  assign done         = done_r;
  assign capture      = capture_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed and randomized checks of mux_sel_sequencer against a cycle-by-cycle
// schedule derived from the programmed table.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [2:0] cfg_sel = 3'd0;
  logic [3:0] cfg_hold = 4'd0;
  logic [3:0] len = 4'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic       sample_valid;
  logic       done;
  logic [7:0] capture;

  logic [7:0]  mux_tbl = 8'h00;
  int unsigned m_sel [8];
  int unsigned m_hold [8];
  logic [7:0]  g_cap = 8'h00;
  int          n_assert = 0;
  int          n_fail = 0;

  // The mux under sequencing: one data bit per select value.
  assign mux_out = mux_tbl[sel];

  always #5 clk = ~clk;

  mux_sel_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_hold(cfg_hold), .len(len), .start(start),
    .abort(abort), .mux_out(mux_out), .sel(sel), .busy(busy),
    .sample_valid(sample_valid), .done(done), .capture(capture)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int s, input int h);
    logic [31:0] av, sv, hv;
    av = a; sv = s; hv = h;
    cfg_we = 1'b1; cfg_addr = av[2:0]; cfg_sel = sv[2:0]; cfg_hold = hv[3:0];
    tick();
    cfg_we = 1'b0;
    m_sel[a] = s; m_hold[a] = h;
  endtask

  task automatic rand_table(input int max_hold);
    for (int k = 0; k < 8; k++) begin
      wr(k, int'($urandom_range(0, 7)), int'($urandom_range(0, max_hold)));
    end
  endtask

  // mode 0: run to completion, 1: abort at a random cycle, 2: abort on first cycle of step 2
  task automatic run_seq(input int l, input int mode);
    int          n, total, ab_at, jmax, lim, ks;
    int          cum [8];
    logic [31:0] lv, rv;
    logic [2:0]  e_sel;
    logic        e_busy, e_sv, e_done;
    logic [7:0]  e_cap;
    n = (l > 8) ? 8 : l;
    total = 0;
    for (int k = 0; k < n; k++) begin
      total += int'(m_hold[k]) + 1;
      cum[k] = total;
    end
    if (mode == 1) ab_at = int'($urandom_range(0, total - 1));
    else if (mode == 2) ab_at = cum[1];
    else ab_at = -1;
    jmax = (ab_at >= 0) ? ab_at + 2 : total + 1;
    lv = l;
    len = lv[3:0]; start = 1'b1; abort = 1'b0; cfg_we = 1'b0;
    tick();
    for (int j = 0; j <= jmax; j++) begin
      e_sel = 3'd0; e_busy = 1'b0; e_sv = 1'b0; e_done = 1'b0; e_cap = 8'h00;
      lim = (ab_at >= 0 && j > ab_at) ? ab_at : j;
      for (int k = 0; k < n; k++) begin
        if (cum[k] <= lim) e_cap[k] = mux_tbl[m_sel[k]];
      end
      if (ab_at < 0 || j <= ab_at) begin
        if (j < total) begin
          e_busy = 1'b1;
          ks = 0;
          while (cum[ks] <= j) ks++;
          e_sel = m_sel[ks][2:0];
        end
        for (int k = 0; k < n; k++) begin
          if (cum[k] == j) e_sv = 1'b1;
        end
        e_done = (j == total);
      end
      chk("sel", 32'(sel), 32'(e_sel));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("sample_valid", 32'(sample_valid), 32'(e_sv));
      chk("done", 32'(done), 32'(e_done));
      chk("capture", 32'(capture), 32'(e_cap));
      g_cap = e_cap;
      // Noise on start/cfg while running must be ignored.
      if (j < total && (ab_at < 0 || j < ab_at)) begin
        rv = $urandom;
        start = rv[0]; cfg_we = rv[1]; cfg_addr = rv[4:2]; cfg_sel = rv[7:5];
        cfg_hold = rv[11:8]; len = rv[15:12];
        abort = 1'b0;
      end else if (j == ab_at) begin
        abort = 1'b1; start = 1'b0; cfg_we = 1'b0;
      end else begin
        abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
      end
      if (j < jmax) tick();
    end
    abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_capture", 32'(capture), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin m_sel[k] = 0; m_hold[k] = 0; end
    tick();

    // Four-step table, sel sequence 2,1,4,4,6, capture 4'b1101
    wr(0, 2, 0); wr(1, 1, 0); wr(2, 4, 1); wr(3, 6, 0);
    mux_tbl = 8'h54;
    run_seq(4, 0);
    chk("t2_capture", 32'(capture[3:0]), 32'hD);

    // Single step with maximum hold
    wr(0, 3, 15);
    run_seq(1, 0);

    // Abort during step 2 of a 4-step run
    mux_tbl = 8'($urandom);
    for (int k = 0; k < 4; k++) wr(k, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
    run_seq(4, 2);

    // Ignored starts
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_capture", 32'(capture), 32'(g_cap));
    start = 1'b1; abort = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_sel", 32'(sel), 32'd0);

    // len beyond DEPTH runs DEPTH steps
    rand_table(3);
    mux_tbl = 8'($urandom);
    run_seq(12, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      rand_table(6);
      mux_tbl = 8'($urandom);
      run_seq(int'($urandom_range(1, 15)), int'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-run clears outputs and the table
    mux_tbl = 8'hFF;
    wr(0, 5, 0); wr(1, 5, 7);
    len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_sel", 32'(sel), 32'd5);
    chk("pre_rst_capture", 32'(capture), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_capture", 32'(capture), 32'd0);
    chk("async_rst_sv", 32'(sample_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin m_sel[k] = 0; m_hold[k] = 0; end
    tick();
    run_seq(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
